// File: rtl/decryption_demux.sv
// Demultiplexer that queues encrypted words in a small FIFO and forwards each to its decryptor.
// Optional dropped-word counter enabled by defining DEMUX_ERR_CNT_EN.
module decryption_demux #(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select_i,
  input  logic [2:0]         busy_i,
  output logic               busy_o,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_CNT = CW'(DEPTH - 1);

  logic [D_WIDTH-1:0] mem_data [DEPTH];
  logic [1:0]         mem_sel  [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  logic [1:0]         head_sel;
  logic [D_WIDTH-1:0] head_data;
  logic [3:0]         busy_ext;
  logic               head_busy, not_empty, full, pop, push, drop;

  // Select code 3 never enters the FIFO; the padded bit keeps the lookup total.
  assign busy_ext  = {1'b1, busy_i};
  assign head_sel  = mem_sel[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign head_busy = busy_ext[head_sel];
  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = not_empty && !head_busy;
  assign push      = valid_i && (select_i != 2'd3) && (!full || pop);
  assign drop      = valid_i && !push;
  assign busy_o    = (count >= HIGH_CNT);

  // Stage 0: FIFO storage (data path, not reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= data_i;
      mem_sel[wr_ptr]  <= select_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage 1: registered per-target outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
    end else begin
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      if (pop) begin
        case (head_sel)
          2'd0: begin data0_o <= head_data; valid0_o <= 1'b1; end
          2'd1: begin data1_o <= head_data; valid1_o <= 1'b1; end
          2'd2: begin data2_o <= head_data; valid2_o <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

`ifdef DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_o <= 8'd0;
    else if (drop && (err_cnt_o != 8'hFF))
      err_cnt_o <= err_cnt_o + 8'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_decryption_demux.sv
// Directed self-checking bench for decryption_demux (DEPTH=4, D_WIDTH=8).
module tb_decryption_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [1:0] select_i;
  logic [2:0] busy_i;
  logic       busy_o;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_o;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decryption_demux #(.D_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .select_i(select_i), .busy_i(busy_i), .busy_o(busy_o),
    .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
    .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o)
`ifdef DEMUX_ERR_CNT_EN
    , .err_cnt_o(err_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expect a strobe on port p (0..2) carrying d, or no strobe at all when p=3.
  task automatic chk_out(input string tag, input int p, input logic [7:0] d);
    chk({tag, " v0"}, {31'd0, valid0_o}, (p == 0) ? 32'd1 : 32'd0);
    chk({tag, " v1"}, {31'd0, valid1_o}, (p == 1) ? 32'd1 : 32'd0);
    chk({tag, " v2"}, {31'd0, valid2_o}, (p == 2) ? 32'd1 : 32'd0);
    chk({tag, " d0"}, {24'd0, data0_o}, (p == 0) ? {24'd0, d} : 32'd0);
    chk({tag, " d1"}, {24'd0, data1_o}, (p == 1) ? {24'd0, d} : 32'd0);
    chk({tag, " d2"}, {24'd0, data2_o}, (p == 2) ? {24'd0, d} : 32'd0);
  endtask

  task automatic chk_err(input string tag, input int exp);
`ifdef DEMUX_ERR_CNT_EN
    chk(tag, {24'd0, err_cnt_o}, exp);
`else
    if (exp < 0) $display("note: %s", tag);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
    valid_i  = v;
    select_i = s;
    data_i   = d;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    busy_i = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    chk_out("reset", 3, 8'h00);
    chk("reset busy_o", {31'd0, busy_o}, 32'd0);
    chk_err("reset err", 0);

    // Basic latency: accept at edge k, strobe after edge k+1
    #9 rst_n = 1'b1;
    drive(1'b1, 2'd0, 8'h41);
    tick;
    drive(1'b0, 2'd0, 8'h00);
    chk_out("lat k", 3, 8'h00);
    tick;
    chk_out("lat k+1", 0, 8'h41);
    tick;
    chk_out("lat k+2", 3, 8'h00);

    // Busy head blocks a later word for an idle target
    busy_i = 3'b010;
    drive(1'b1, 2'd1, 8'h10); tick;
    drive(1'b1, 2'd0, 8'h20); tick;
    drive(1'b0, 2'd0, 8'h00); tick;
    chk_out("hol blocked", 3, 8'h00);
    chk("hol busy_o", {31'd0, busy_o}, 32'd0);
    busy_i = 3'b000;
    tick; chk_out("hol first", 1, 8'h10);
    tick; chk_out("hol second", 0, 8'h20);
    tick; chk_out("hol idle", 3, 8'h00);

    // Fill to full, drop the overflow word, then drain in order
    busy_i = 3'b111;
    drive(1'b1, 2'd0, 8'hA0); tick;
    drive(1'b1, 2'd1, 8'hA1); tick;
    chk("fill busy_o@2", {31'd0, busy_o}, 32'd0);
    drive(1'b1, 2'd2, 8'hA2); tick;
    chk("fill busy_o@3", {31'd0, busy_o}, 32'd1);
    drive(1'b1, 2'd0, 8'hA3); tick;
    drive(1'b1, 2'd1, 8'hA4); tick;
    drive(1'b0, 2'd0, 8'h00); tick;
    chk_out("full held", 3, 8'h00);
    chk("full busy_o", {31'd0, busy_o}, 32'd1);
    chk_err("overflow err", 1);
    busy_i = 3'b000;
    tick; chk_out("drain A0", 0, 8'hA0);
    chk("drain busy_o cnt3", {31'd0, busy_o}, 32'd1);
    tick; chk_out("drain A1", 1, 8'hA1);
    chk("drain busy_o cnt2", {31'd0, busy_o}, 32'd0);
    tick; chk_out("drain A2", 2, 8'hA2);
    tick; chk_out("drain A3", 0, 8'hA3);
    tick; chk_out("drain end", 3, 8'h00);

    // Invalid select is dropped
    drive(1'b1, 2'd3, 8'h55); tick;
    drive(1'b0, 2'd0, 8'h00); tick;
    chk_out("sel3 none", 3, 8'h00);
    chk("sel3 busy_o", {31'd0, busy_o}, 32'd0);
    chk_err("sel3 err", 2);

    // Push on the same edge as a pop while full
    busy_i = 3'b001;
    drive(1'b1, 2'd0, 8'hB0); tick;
    drive(1'b1, 2'd0, 8'hB1); tick;
    drive(1'b1, 2'd0, 8'hB2); tick;
    drive(1'b1, 2'd0, 8'hB3); tick;
    busy_i = 3'b000;
    drive(1'b1, 2'd0, 8'hB4); tick;
    drive(1'b0, 2'd0, 8'h00);
    chk_out("pushpop B0", 0, 8'hB0);
    chk("pushpop busy_o", {31'd0, busy_o}, 32'd1);
    chk_err("pushpop err", 2);
    tick; chk_out("pushpop B1", 0, 8'hB1);
    tick; chk_out("pushpop B2", 0, 8'hB2);
    tick; chk_out("pushpop B3", 0, 8'hB3);
    tick; chk_out("pushpop B4", 0, 8'hB4);
    tick; chk_out("pushpop end", 3, 8'h00);

    // Asynchronous reset with words queued and a strobe showing
    busy_i = 3'b111;
    drive(1'b1, 2'd1, 8'hC0); tick;
    drive(1'b1, 2'd2, 8'hC1); tick;
    drive(1'b1, 2'd1, 8'hC2); tick;
    drive(1'b1, 2'd0, 8'hC3); tick;
    drive(1'b0, 2'd0, 8'h00);
    busy_i = 3'b101;
    tick;
    chk_out("pre-reset C0", 1, 8'hC0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async reset", 3, 8'h00);
    chk("async busy_o", {31'd0, busy_o}, 32'd0);
    chk_err("async err", 0);
    busy_i = 3'b000;
    tick;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_out("flushed", 3, 8'h00);
    end

    // First edge after release accepts
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b1, 2'd2, 8'hD7); tick;
    drive(1'b0, 2'd0, 8'h00); tick;
    chk_out("first accept", 2, 8'hD7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
